// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier: one multiplier bit per clock, signed or unsigned per operation.
// Operands are reduced to magnitudes up front; the product sign is restored in the final cycle.
module seq_mult_param #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 sign,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mag_b_q, mag_b_d;
  logic [2*WIDTH-1:0]   mcand_sh_q, mcand_sh_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic                 sign_q, sign_d;
  logic                 done_q, done_d;

  logic                 neg_a, neg_b;
  logic [WIDTH-1:0]     mag_a, mag_b;

  // The most negative operand negates to 2^(WIDTH-1), which still fits an unsigned WIDTH-bit reg.
  always_comb begin
    neg_a = signed_mode & multiplicand[WIDTH-1];
    neg_b = signed_mode & multiplier[WIDTH-1];
    mag_a = neg_a ? -multiplicand : multiplicand;
    mag_b = neg_b ? -multiplier : multiplier;
  end

  always_comb begin
    state_d    = state_q;
    mag_b_d    = mag_b_q;
    mcand_sh_d = mcand_sh_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    product_d  = product_q;
    sign_d     = sign_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mag_b_d    = mag_b;
          mcand_sh_d = {{WIDTH{1'b0}}, mag_a};
          acc_d      = '0;
          cnt_d      = '0;
          neg_d      = neg_a ^ neg_b;
          state_d    = StRun;
        end
      end
      StRun: begin
        if (mag_b_q[0]) acc_d = acc_q + mcand_sh_q;
        mcand_sh_d = mcand_sh_q << 1;
        mag_b_d    = mag_b_q >> 1;
        cnt_d      = cnt_q + 1'b1;
        // Fixed WIDTH iterations regardless of data, so latency never varies.
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StFinish;
      end
      StFinish: begin
        product_d = neg_q ? -acc_q : acc_q;
        sign_d    = neg_q & (acc_q != '0);
        done_d    = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mag_b_q    <= '0;
      mcand_sh_q <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      product_q  <= '0;
      sign_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mag_b_q    <= mag_b_d;
      mcand_sh_q <= mcand_sh_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      product_q  <= product_d;
      sign_q     <= sign_d;
      done_q     <= done_d;
    end
  end

  assign product = product_q;
  assign sign    = sign_q;
  assign busy    = (state_q != StIdle);
  assign done    = done_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Randomised and directed checks of seq_mult_param at WIDTH=8 and WIDTH=16 against an
// integer-arithmetic reference model.
module tb_seq_mult_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        signed_mode = 1'b0;
  logic        start8 = 1'b0, start16 = 1'b0;
  logic [7:0]  mcand8 = '0, mplier8 = '0;
  logic [15:0] mcand16 = '0, mplier16 = '0;
  logic [15:0] prod8;
  logic [31:0] prod16;
  logic        sign8, busy8, done8, sign16, busy16, done16;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] last8 = '0, last16 = '0;

  always #5 clk = ~clk;

  seq_mult_param #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(signed_mode),
    .multiplicand(mcand8), .multiplier(mplier8),
    .product(prod8), .sign(sign8), .busy(busy8), .done(done8)
  );

  seq_mult_param #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(signed_mode),
    .multiplicand(mcand16), .multiplier(mplier16),
    .product(prod16), .sign(sign16), .busy(busy16), .done(done16)
  );

  // True integer product of the operands as interpreted in the given mode, truncated to 2w bits.
  function automatic void model(input int w, input logic sm, input logic [15:0] a,
                                input logic [15:0] b, output logic [31:0] p, output logic s);
    longint av, bv, pv, mask;
    mask = (longint'(1) << w) - 1;
    av = longint'(a) & mask;
    bv = longint'(b) & mask;
    if (sm && a[w-1]) av = av - (longint'(1) << w);
    if (sm && b[w-1]) bv = bv - (longint'(1) << w);
    pv = av * bv;
    p  = 32'(pv & ((longint'(1) << (2 * w)) - 1));
    s  = (pv < 0);
  endfunction

  function automatic void observe(input int w, output logic [31:0] p, output logic s,
                                  output logic bz, output logic d);
    if (w == 8) begin
      p = {16'h0, prod8}; s = sign8; bz = busy8; d = done8;
    end else begin
      p = prod16; s = sign16; bz = busy16; d = done16;
    end
  endfunction

  task automatic run_op(input int w, input logic sm, input logic [15:0] a, input logic [15:0] b,
                        input string tag);
    logic [31:0] ep, p, held;
    logic        es, s, bz, d;
    int          edges;
    model(w, sm, a, b, ep, es);
    held = (w == 8) ? last8 : last16;
    @(negedge clk);
    signed_mode = sm;
    mcand8 = a[7:0]; mplier8 = b[7:0]; mcand16 = a; mplier16 = b;
    if (w == 8) start8 = 1'b1; else start16 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; start16 = 1'b0;
    observe(w, p, s, bz, d);
    checks++;
    if (bz !== 1'b1 || d !== 1'b0 || p !== held) begin
      failures++;
      $display("FAIL %s accept: busy=%b done=%b product=%h, want busy=1 done=0 product=%h",
               tag, bz, d, p, held);
    end
    edges = 0;
    d = 1'b0;
    while (!d && edges < 4 * w) begin
      @(posedge clk); #1;
      edges++;
      observe(w, p, s, bz, d);
      if (!d && bz !== 1'b1) begin
        checks++; failures++;
        $display("FAIL %s busy at edge %0d: got %b want 1", tag, edges, bz);
      end
    end
    checks++;
    if (!d) begin
      failures++;
      $display("FAIL %s timeout: no done within %0d edges", tag, edges);
    end else if (edges !== w + 1 || p !== ep || s !== es || bz !== 1'b0) begin
      failures++;
      $display("FAIL %s result: edge=%0d product=%h sign=%b busy=%b, want edge=%0d product=%h sign=%b busy=0",
               tag, edges, p, s, bz, w + 1, ep, es);
    end
    if (w == 8) last8 = ep; else last16 = ep;
    @(posedge clk); #1;
    observe(w, p, s, bz, d);
    checks++;
    if (d !== 1'b0 || bz !== 1'b0) begin
      failures++;
      $display("FAIL %s pulse: done=%b busy=%b after done cycle, want 0 0", tag, d, bz);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (prod8 !== 16'h0 || sign8 !== 1'b0 || busy8 !== 1'b0 || done8 !== 1'b0 ||
        prod16 !== 32'h0 || busy16 !== 1'b0 || done16 !== 1'b0) begin
      failures++;
      $display("FAIL reset: p8=%h s8=%b b8=%b d8=%b p16=%h b16=%b d16=%b, want all 0",
               prod8, sign8, busy8, done8, prod16, busy16, done16);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed8();
    run_op(8, 1'b1, 16'h0007, 16'h00FD, "s8_7xm3");
    run_op(8, 1'b1, 16'h0080, 16'h0080, "s8_m128sq");
    run_op(8, 1'b1, 16'h0080, 16'h0001, "s8_m128x1");
    run_op(8, 1'b0, 16'h00FF, 16'h00FF, "u8_ffxff");
    run_op(8, 1'b1, 16'h00FF, 16'h00FF, "s8_m1xm1");
    run_op(8, 1'b1, 16'h0000, 16'h00FB, "s8_0xm5");
  endtask

  task automatic test_random8();
    for (int i = 0; i < 20; i++)
      run_op(8, 1'($urandom), 16'($urandom_range(255)), 16'($urandom_range(255)), "rand8");
  endtask

  task automatic test_busy_ignored();
    logic [31:0] p;
    logic        s, bz, d;
    int          edges, extra;
    @(negedge clk);
    signed_mode = 1'b0; mcand8 = 8'd5; mplier8 = 8'd5; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start8 = 1'b1; mcand8 = 8'd9; mplier8 = 8'd9;
    @(posedge clk); #1;
    start8 = 1'b0;
    edges = 4;
    d = 1'b0;
    while (!d && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      observe(8, p, s, bz, d);
    end
    checks++;
    if (!d || edges !== 9 || p !== 32'd25 || s !== 1'b0) begin
      failures++;
      $display("FAIL busy_ignored: done=%b edge=%0d product=%0d sign=%b, want done at 9 product=25 sign=0",
               d, edges, p, s);
    end
    extra = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done8) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL busy_ignored_extra: %0d extra done pulses, want 0", extra);
    end
    last8 = 32'd25;
  endtask

  task automatic test_back_to_back();
    logic [15:0] a[4], b[4];
    logic [31:0] ep, p;
    logic        es, s, bz, d;
    int          edges;
    for (int i = 0; i < 4; i++) begin
      a[i] = 16'($urandom_range(255));
      b[i] = 16'($urandom_range(255));
    end
    @(negedge clk);
    signed_mode = 1'b1; mcand8 = a[0][7:0]; mplier8 = b[0][7:0]; start8 = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      mcand8 = a[i+1][7:0]; mplier8 = b[i+1][7:0];
      model(8, 1'b1, a[i], b[i], ep, es);
      edges = 0;
      d = 1'b0;
      while (!d && edges < 40) begin
        @(posedge clk); #1;
        edges++;
        observe(8, p, s, bz, d);
      end
      checks++;
      if (!d || edges !== 9 || p !== ep || s !== es) begin
        failures++;
        $display("FAIL b2b op%0d: done=%b edge=%0d product=%h sign=%b, want edge 9 product=%h sign=%b",
                 i, d, edges, p, s, ep, es);
      end
      last8 = ep;
      if (i == 2) start8 = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (busy8 !== (i < 2)) begin
        failures++;
        $display("FAIL b2b accept%0d: busy=%b, want %b", i, busy8, (i < 2));
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int extra;
    @(negedge clk);
    signed_mode = 1'b0; mcand8 = 8'd100; mplier8 = 8'd100; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (prod8 !== 16'h0 || busy8 !== 1'b0 || done8 !== 1'b0 || sign8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: product=%h busy=%b done=%b sign=%b, want 0 0 0 0",
               prod8, busy8, done8, sign8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done8) extra++;
    end
    checks++;
    if (extra !== 0 || prod8 !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid_after: done pulses=%0d product=%h, want 0 and 0", extra, prod8);
    end
    last8 = '0;
    last16 = '0;
  endtask

  task automatic test_width16();
    run_op(16, 1'b1, 16'h8000, 16'h8000, "s16_min_sq");
    run_op(16, 1'b1, 16'h0007, 16'hFFFD, "s16_7xm3");
    run_op(16, 1'b0, 16'hFFFF, 16'hFFFF, "u16_max_sq");
    run_op(16, 1'b1, 16'h0000, 16'hFFFB, "s16_0xm5");
    for (int i = 0; i < 10; i++)
      run_op(16, 1'($urandom), 16'($urandom), 16'($urandom), "rand16");
  endtask

  initial begin
    test_reset();
    test_directed8();
    test_random8();
    test_busy_ignored();
    test_back_to_back();
    test_reset_mid_op();
    test_width16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
